// File: rtl/accel_job_scheduler.sv
// In-order job queue feeding the FFT and crypto accelerators through start/done
// handshakes, with a register-bus front end, completion counter and level interrupt.
module accel_job_scheduler #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int DONE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [18:0] bus_addr,
  input  logic [18:0] bus_wdata,
  output logic [18:0] bus_rdata,
  output logic        fft_start,
  output logic [17:0] fft_cfg,
  input  logic        fft_done,
  output logic        crypto_start,
  output logic [17:0] crypto_cfg,
  input  logic        crypto_done,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} acc_state_t;

  acc_state_t        fft_state, crypto_state;
  logic [18:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow, irq_en;
  logic [DONE_W-1:0] done_count, done_next;
  logic [DONE_W:0]   done_sum;
  logic [1:0]        done_inc;
  logic [18:0]       head, status;
  logic              wr_acc, rd_acc, empty, full, push_req, push, pop;
  logic              pop_fft, pop_crypto, fft_fin, crypto_fin, clr_done;
  logic              unused_addr;

  assign unused_addr = ^bus_addr[18:2];

  assign wr_acc   = bus_valid & bus_write;
  assign rd_acc   = bus_valid & ~bus_write;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_req = wr_acc & (bus_addr[1:0] == 2'd0);
  assign push     = push_req & ~full;
  assign clr_done = wr_acc & (bus_addr[1:0] == 2'd2);

  // Strict head-of-line dispatch: a busy target stalls the whole queue.
  assign head       = mem[rd_ptr];
  assign pop        = ~empty & (head[18] ? (crypto_state == S_IDLE) : (fft_state == S_IDLE));
  assign pop_fft    = pop & ~head[18];
  assign pop_crypto = pop & head[18];

  assign fft_fin    = (fft_state == S_BUSY) & fft_done;
  assign crypto_fin = (crypto_state == S_BUSY) & crypto_done;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_acc && bus_addr[1:0] == 2'd1 && bus_wdata[4])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_state <= S_IDLE;
      fft_start <= 1'b0;
      fft_cfg   <= '0;
    end else begin
      case (fft_state)
        S_IDLE: if (pop_fft) begin
          fft_state <= S_START;
          fft_start <= 1'b1;
          fft_cfg   <= head[17:0];
        end
        S_START: begin
          fft_state <= S_BUSY;
          fft_start <= 1'b0;
        end
        S_BUSY: if (fft_done) fft_state <= S_IDLE;
        default: begin
          fft_state <= S_IDLE;
          fft_start <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crypto_state <= S_IDLE;
      crypto_start <= 1'b0;
      crypto_cfg   <= '0;
    end else begin
      case (crypto_state)
        S_IDLE: if (pop_crypto) begin
          crypto_state <= S_START;
          crypto_start <= 1'b1;
          crypto_cfg   <= head[17:0];
        end
        S_START: begin
          crypto_state <= S_BUSY;
          crypto_start <= 1'b0;
        end
        S_BUSY: if (crypto_done) crypto_state <= S_IDLE;
        default: begin
          crypto_state <= S_IDLE;
          crypto_start <= 1'b0;
        end
      endcase
    end
  end

  // Clear is applied first so a coinciding completion still counts.
  always_comb begin
    done_inc  = {1'b0, fft_fin} + {1'b0, crypto_fin};
    done_sum  = {1'b0, (clr_done ? '0 : done_count)} + (DONE_W+1)'(done_inc);
    done_next = done_sum[DONE_W] ? '1 : done_sum[DONE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      done_count <= done_next;
      if (wr_acc && bus_addr[1:0] == 2'd3) irq_en <= bus_wdata[0];
      irq <= irq_en & (done_count != '0);
    end
  end

  always_comb begin
    status = '0;
    status[0] = empty;
    status[1] = full;
    status[2] = (fft_state != S_IDLE);
    status[3] = (crypto_state != S_IDLE);
    status[4] = overflow;
    status[5 +: CNT_W] = count;
    bus_rdata = '0;
    if (rd_acc) begin
      case (bus_addr[1:0])
        2'd1:    bus_rdata = status;
        2'd2:    bus_rdata = 19'(done_count);
        2'd3:    bus_rdata = {18'b0, irq_en};
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Directed bench for accel_job_scheduler: a per-cycle vector table for the basic
// dispatch/irq flow, then hand sequences for stalls, overflow, counting and reset.
module tb_accel_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid, bus_write, fft_done, crypto_done;
  logic [18:0] bus_addr, bus_wdata, bus_rdata;
  logic        fft_start, crypto_start, irq;
  logic [17:0] fft_cfg, crypto_cfg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  accel_job_scheduler #(.DEPTH(8), .CNT_W(4), .DONE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .fft_start(fft_start), .fft_cfg(fft_cfg), .fft_done(fft_done),
    .crypto_start(crypto_start), .crypto_cfg(crypto_cfg), .crypto_done(crypto_done),
    .irq(irq)
  );

  typedef struct {
    logic        v, w;
    logic [1:0]  a;
    logic [18:0] d;
    logic        fd, cd;
    logic [18:0] exp_rdata;
    logic        exp_fs, exp_cs, exp_irq;
    logic [17:0] exp_fcfg;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, w, input logic [1:0] a, input logic [18:0] d,
                              input logic fd, cd, input logic [18:0] er,
                              input logic efs, ecs, eirq, input logic [17:0] efc);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.d = d; r.fd = fd; r.cd = cd;
    r.exp_rdata = er; r.exp_fs = efs; r.exp_cs = ecs; r.exp_irq = eirq; r.exp_fcfg = efc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs change just after the falling edge, checks follow 1ns later.
  task automatic cycle(input logic v, w, input logic [1:0] a, input logic [18:0] d,
                       input logic fd, cd);
    @(negedge clk);
    bus_valid = v; bus_write = w; bus_addr = {17'b0, a}; bus_wdata = d;
    fft_done = fd; crypto_done = cd;
    #1;
  endtask

  task automatic idle();                    cycle(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0); endtask
  task automatic push(input logic [18:0] d); cycle(1'b1, 1'b1, 2'd0, d, 1'b0, 1'b0);  endtask
  task automatic rd(input logic [1:0] a);    cycle(1'b1, 1'b0, a, '0, 1'b0, 1'b0);    endtask

  initial begin
    int found, starts;
    bus_valid = 0; bus_write = 0; bus_addr = '0; bus_wdata = '0;
    fft_done = 0; crypto_done = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //              v  w  a  d         fd cd  rdata     fs cs irq fft_cfg
    tbl[0]  = mk(1, 0, 1, 19'h0,     0, 0, 19'h001, 0, 0, 0, 18'h0);
    tbl[1]  = mk(1, 1, 3, 19'h1,     0, 0, 19'h000, 0, 0, 0, 18'h0);
    tbl[2]  = mk(1, 1, 0, 19'h00123, 0, 0, 19'h000, 0, 0, 0, 18'h0);
    tbl[3]  = mk(1, 0, 1, 19'h0,     0, 0, 19'h020, 0, 0, 0, 18'h0);
    tbl[4]  = mk(1, 0, 1, 19'h0,     0, 0, 19'h005, 1, 0, 0, 18'h00123);
    tbl[5]  = mk(1, 0, 3, 19'h0,     0, 0, 19'h001, 0, 0, 0, 18'h00123);
    tbl[6]  = mk(0, 0, 0, 19'h0,     0, 0, 19'h000, 0, 0, 0, 18'h00123);
    tbl[7]  = mk(0, 0, 0, 19'h0,     0, 0, 19'h000, 0, 0, 0, 18'h00123);
    tbl[8]  = mk(0, 0, 0, 19'h0,     0, 0, 19'h000, 0, 0, 0, 18'h00123);
    tbl[9]  = mk(0, 0, 0, 19'h0,     1, 0, 19'h000, 0, 0, 0, 18'h00123);
    tbl[10] = mk(1, 0, 2, 19'h0,     0, 0, 19'h001, 0, 0, 0, 18'h00123);
    tbl[11] = mk(1, 0, 1, 19'h0,     0, 0, 19'h001, 0, 0, 1, 18'h00123);
    tbl[12] = mk(1, 1, 2, 19'h0,     0, 0, 19'h000, 0, 0, 1, 18'h00123);
    tbl[13] = mk(1, 0, 2, 19'h0,     0, 0, 19'h000, 0, 0, 1, 18'h00123);
    tbl[14] = mk(1, 0, 2, 19'h0,     0, 0, 19'h000, 0, 0, 0, 18'h00123);
    tbl[15] = mk(1, 0, 1, 19'h0,     0, 0, 19'h001, 0, 0, 0, 18'h00123);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].fd, tbl[i].cd);
      chk($sformatf("tbl%0d rdata", i),    bus_rdata,           tbl[i].exp_rdata);
      chk($sformatf("tbl%0d fft_start", i), 19'(fft_start),     19'(tbl[i].exp_fs));
      chk($sformatf("tbl%0d crypto_start", i), 19'(crypto_start), 19'(tbl[i].exp_cs));
      chk($sformatf("tbl%0d irq", i),       19'(irq),           19'(tbl[i].exp_irq));
      chk($sformatf("tbl%0d fft_cfg", i),   19'(fft_cfg),       19'(tbl[i].exp_fcfg));
    end

    // Head-of-line blocking: FFT A, FFT B, crypto C.
    push(19'h0000A);
    push(19'h0000B);
    push(19'h4000C);
    chk("hol A start", 19'(fft_start), 19'h1);
    chk("hol A cfg",   19'(fft_cfg),   19'h0000A);
    rd(2'd1);
    chk("hol status", bus_rdata, 19'h044);
    chk("hol fft_start low", 19'(fft_start), 19'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("hol C blocked %0d", i), 19'(crypto_start), 19'h0);
    end
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("hol C blocked at done", 19'(crypto_start), 19'h0);
    idle();
    chk("hol B not yet", 19'(fft_start), 19'h0);
    idle();
    chk("hol B start", 19'(fft_start), 19'h1);
    chk("hol B cfg",   19'(fft_cfg),   19'h0000B);
    chk("hol C not yet", 19'(crypto_start), 19'h0);
    idle();
    chk("hol C start", 19'(crypto_start), 19'h1);
    chk("hol C cfg",   19'(crypto_cfg),   19'h0000C);
    chk("hol B start low", 19'(fft_start), 19'h0);

    // Both completions in one cycle add two.
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1);
    rd(2'd2);
    chk("dual done count", bus_rdata, 19'h003);
    rd(2'd1);
    chk("dual done idle status", bus_rdata, 19'h001);

    // Clear coinciding with a completion keeps that completion.
    push(19'h0000D);
    idle(); idle(); idle();
    cycle(1'b1, 1'b1, 2'd2, '0, 1'b1, 1'b0);
    rd(2'd2);
    chk("clear+done count", bus_rdata, 19'h001);

    // Spurious done in IDLE and in START.
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    rd(2'd2);
    chk("spur idle count", bus_rdata, 19'h001);
    push(19'h0000E);
    idle();
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("spur start pulse", 19'(fft_start), 19'h1);
    rd(2'd1);
    chk("spur still busy", bus_rdata, 19'h005);
    rd(2'd2);
    chk("spur start count", bus_rdata, 19'h001);
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    rd(2'd1);
    chk("spur real done idle", bus_rdata, 19'h001);
    rd(2'd2);
    chk("spur real done count", bus_rdata, 19'h002);

    // Overflow: FFT held busy, nine more FFT jobs pushed.
    push(19'h000AA);
    idle(); idle(); idle();
    for (int i = 0; i < 9; i++) push(19'(32'h100 + i));
    rd(2'd1);
    chk("ovf status", bus_rdata, 19'h116);
    cycle(1'b1, 1'b1, 2'd1, 19'h00010, 1'b0, 1'b0);
    rd(2'd1);
    chk("ovf cleared", bus_rdata, 19'h106);
    for (int j = 0; j < 8; j++) begin
      cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
      found = 0;
      for (int k = 0; k < 8 && found == 0; k++) begin
        idle();
        if (fft_start === 1'b1) found = 1;
      end
      chk($sformatf("drain%0d start", j), 19'(found), 19'h1);
      chk($sformatf("drain%0d cfg", j), 19'(fft_cfg), 19'(32'h100 + j));
    end
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    starts = 0;
    repeat (10) begin
      idle();
      if (fft_start !== 1'b0) starts++;
    end
    chk("ninth never starts", 19'(starts), 19'h0);
    rd(2'd1);
    chk("drained status", bus_rdata, 19'h001);

    // Asynchronous reset with crypto busy and three jobs queued.
    push(19'h40077);
    push(19'h40001);
    push(19'h40002);
    push(19'h40003);
    rd(2'd1);
    chk("pre-rst status", bus_rdata, 19'h068);
    chk("pre-rst crypto_cfg", 19'(crypto_cfg), 19'h00077);
    chk("pre-rst irq", 19'(irq), 19'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst fft_start",    19'(fft_start),    19'h0);
    chk("rst fft_cfg",      19'(fft_cfg),      19'h0);
    chk("rst crypto_start", 19'(crypto_start), 19'h0);
    chk("rst crypto_cfg",   19'(crypto_cfg),   19'h0);
    chk("rst irq",          19'(irq),          19'h0);
    chk("rst status",       bus_rdata,         19'h001);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    rd(2'd1);
    chk("post-rst status", bus_rdata, 19'h001);
    chk("post-rst crypto_start", 19'(crypto_start), 19'h0);
    rd(2'd2);
    chk("post-rst done count", bus_rdata, 19'h000);
    rd(2'd3);
    chk("post-rst irq_en", bus_rdata, 19'h000);
    chk("post-rst irq", 19'(irq), 19'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
